rs_ff_driver: RTL and testbench
===============================

Name: rs_ff_driver

Overview:
- Stimulus generator and checker for the clocked RS flip-flop interface. It drives the r/s inputs of a flip-flop and reads back its q/qb outputs.
- On each start request it runs a fixed 8-step set/clear/hold sequence and never drives the forbidden r=s=1 combination.
- It compares q/qb against an internal expected model and reports a pass/fail result and error details.
- It sits on the board top level beside the flip-flop, with results routed to LEDs.

Parameters:
- HOLD_CYCLES, default 4: clock cycles each r/s pattern is held before the next step. Legal range 2..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  level/pulse request; sampled only in IDLE and DONE
- q  input  1  flip-flop true output
- qb  input  1  flip-flop complementary output
- r  output  1  reset (clear) drive to flip-flop, registered
- s  output  1  set drive to flip-flop, registered
- busy  output  1  high while the sequence is running
- done  output  1  high in DONE, held until restart or reset
- pass  output  1  valid when done=1; 1 iff err_cnt==0
- err_cnt  output  4  number of failed steps, 0..8
- first_fail  output  3  index of first failing step; 0 when none failed
- fail_seen  output  1  set at first failure, sticky until restart or reset
- step  output  3  current step index (debug/LED)

Behaviour:
- Reset (rst=1 at posedge, the only reset), next cycle:
  - r=0, s=0, busy=0, done=0, pass=0.
  - err_cnt=0, first_fail=0, fail_seen=0, step=0, hold counter=0.
  - State=IDLE. Applies equally mid-sequence; the current step is abandoned.
- States: IDLE, RUN, DONE.
- IDLE:
  - r=s=0.
  - start=1 -> RUN at next edge: step=0, r/s loaded with pattern 0, busy=1, result fields cleared.
- RUN:
  - Step table, {r,s} / expected q: 0:10/0, 1:00/0, 2:01/1, 3:00/1, 4:10/0, 5:01/1, 6:10/0, 7:00/0.
  - Each pattern is held exactly HOLD_CYCLES cycles; the hold counter runs 0..HOLD_CYCLES-1.
  - Check happens in the cycle where counter==HOLD_CYCLES-1:
    - Sample q/qb. Because the flip-flop has one-cycle latency, q reflects the pattern applied at least HOLD_CYCLES-1 cycles earlier.
    - The step fails if q!=expected OR qb!=~q. A step counts at most one error.
    - On failure: err_cnt+=1. If fail_seen=0, latch first_fail=step and set fail_seen=1.
  - Same edge as the check: if step<7, step+=1, counter=0, r/s loaded with the next pattern with no gap cycle. If step==7, go to DONE.
  - start is ignored while busy.
  - r=s=1 is never driven in any state.
- DONE:
  - r=s=0, busy=0, done=1, pass=(err_cnt==0).
  - Result fields are stable.
  - start=1 -> clear results and re-enter RUN at step 0 exactly as from IDLE; done drops on that edge.
- Timing: start sampled at edge E0 -> pattern 0 on r/s after E0 -> done=1 after edge E0+8*HOLD_CYCLES. With the default, that is 32 cycles after the start edge, 33 cycles including the start cycle.
- Overflow: err_cnt max 8, so the 4-bit counter never overflows. No saturation logic is needed.

Test Plan:
- Correct flip-flop model, HOLD_CYCLES=4, 1-cycle start pulse -> r/s sequence 10,00,01,00,10,01,10,00, each held 4 cycles. Then done=1 exactly 32 edges after start, pass=1, err_cnt=0, fail_seen=0, r=s=0.
- Flip-flop with q stuck at 0 -> steps 2, 3, 5 fail. err_cnt=3, first_fail=2, fail_seen=1, pass=0.
- Faulty qb (qb=q) -> all 8 steps fail. err_cnt=8, first_fail=0, fail_seen=1, pass=0.
- start held high or re-pulsed during RUN -> no restart, step sequence unaffected. After done, a new start clears results and reruns, giving done again 32 cycles later.
- rst asserted during step 3 -> next cycle r=s=0, busy=0, done=0, err_cnt=0, step=0. A subsequent start runs the full sequence with pass=1.
- HOLD_CYCLES=2 with the correct model -> each pattern held 2 cycles, pass=1, done 16 edges after start. Checker never sees stale q due to flip-flop latency.
- All scenarios: assertion that {r,s}!=11 on every cycle.

Source files
------------

// File: rtl/rs_ff_driver.sv
// rs_ff_driver: stimulus generator and checker for a clocked RS flip-flop.
// Each start runs an 8-step set/clear/hold pattern on r/s. Each pattern is
// held for HOLD_CYCLES cycles. q/qb are checked on the last cycle of every
// hold. Results stay on the outputs until the next start or reset.
module rs_ff_driver #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q,
    input  logic       qb,
    output logic       r,
    output logic       s,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail,
    output logic       fail_seen,
    output logic [2:0] step
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_STEP = 3'd7;

    state_t     state, state_nxt;
    logic [7:0] hcnt, hcnt_nxt;
    logic [2:0] step_nxt;
    logic [3:0] err_nxt;
    logic [2:0] first_fail_nxt;
    logic       fail_seen_nxt;
    logic       r_nxt, s_nxt;
    logic       step_fail;

    // {r,s} drive for each step. The table has no 2'b11 entry, so the
    // forbidden combination cannot reach the flip-flop.
    function automatic logic [1:0] step_rs(input logic [2:0] idx);
        case (idx)
            3'd0:    step_rs = 2'b10;
            3'd1:    step_rs = 2'b00;
            3'd2:    step_rs = 2'b01;
            3'd3:    step_rs = 2'b00;
            3'd4:    step_rs = 2'b10;
            3'd5:    step_rs = 2'b01;
            3'd6:    step_rs = 2'b10;
            default: step_rs = 2'b00;
        endcase
    endfunction

    // Expected q once each step's pattern has settled through the flip-flop.
    function automatic logic step_q(input logic [2:0] idx);
        case (idx)
            3'd2, 3'd3, 3'd5: step_q = 1'b1;
            default:          step_q = 1'b0;
        endcase
    endfunction

    // A step fails on a wrong q, or on qb not being the complement of q.
    assign step_fail = (q != step_q(step)) || (qb != ~q);

    // State and datapath registers, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            step       <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            r          <= 1'b0;
            s          <= 1'b0;
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            step       <= step_nxt;
            err_cnt    <= err_nxt;
            first_fail <= first_fail_nxt;
            fail_seen  <= fail_seen_nxt;
            r          <= r_nxt;
            s          <= s_nxt;
        end
    end

    // Next-state logic: start and restart, hold counting, per-step check,
    // and stepping through the pattern table.
    always_comb begin
        state_nxt      = state;
        hcnt_nxt       = hcnt;
        step_nxt       = step;
        err_nxt        = err_cnt;
        first_fail_nxt = first_fail;
        fail_seen_nxt  = fail_seen;
        r_nxt          = 1'b0;
        s_nxt          = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = RUN;
                    hcnt_nxt       = '0;
                    step_nxt       = '0;
                    err_nxt        = '0;
                    first_fail_nxt = '0;
                    fail_seen_nxt  = 1'b0;
                    {r_nxt, s_nxt} = step_rs(3'd0);
                end
            end
            RUN: begin
                {r_nxt, s_nxt} = {r, s};
                if (hcnt == HOLD_LAST) begin
                    if (step_fail) begin
                        err_nxt = err_cnt + 4'd1;
                        if (!fail_seen) begin
                            first_fail_nxt = step;
                            fail_seen_nxt  = 1'b1;
                        end
                    end
                    hcnt_nxt = '0;
                    if (step != LAST_STEP) begin
                        // The next pattern follows with no gap cycle.
                        step_nxt       = step + 3'd1;
                        {r_nxt, s_nxt} = step_rs(step + 3'd1);
                    end else begin
                        state_nxt      = DONE;
                        {r_nxt, s_nxt} = 2'b00;
                    end
                end else begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == 4'd0);

endmodule

// File: tb/tb_rs_ff_driver.sv
// Self-checking bench for rs_ff_driver. It uses two instances: one with the
// default HOLD_CYCLES=4 and one with HOLD_CYCLES=2. Each instance drives a
// behavioural RS flip-flop that can have a planted fault.
// Fault modes: 0 = correct, 1 = q stuck at 0, 2 = qb equal to q.
module tb_rs_ff_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_i [2];
    logic       q_i     [2];
    logic       qb_i    [2];
    logic       r_o     [2];
    logic       s_o     [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic [3:0] err_o   [2];
    logic [2:0] ff_o    [2];
    logic       fs_o    [2];
    logic [2:0] step_o  [2];
    logic       qm      [2];
    int         mode    [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int err;
        int ff;
        int fs;
        int pass;
    } exp_t;
    exp_t sb[$];

    rs_ff_driver #(.HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_i[0]), .q(q_i[0]), .qb(qb_i[0]),
        .r(r_o[0]), .s(s_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_cnt(err_o[0]), .first_fail(ff_o[0]), .fail_seen(fs_o[0]), .step(step_o[0])
    );

    rs_ff_driver #(.HOLD_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_i[1]), .q(q_i[1]), .qb(qb_i[1]),
        .r(r_o[1]), .s(s_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_cnt(err_o[1]), .first_fail(ff_o[1]), .fail_seen(fs_o[1]), .step(step_o[1])
    );

    // Behavioural clocked RS flip-flop with one cycle of latency. Set wins,
    // although the driver must never assert both inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst)         qm[i] <= 1'b0;
            else if (s_o[i]) qm[i] <= 1'b1;
            else if (r_o[i]) qm[i] <= 1'b0;
        end
    end

    assign q_i[0]  = (mode[0] == 1) ? 1'b0 : qm[0];
    assign qb_i[0] = (mode[0] == 2) ? q_i[0] : ~q_i[0];
    assign q_i[1]  = (mode[1] == 1) ? 1'b0 : qm[1];
    assign qb_i[1] = (mode[1] == 2) ? q_i[1] : ~q_i[1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // The forbidden r=s=1 combination is checked on every cycle of every scenario.
    always @(negedge clk) begin
        chk("rs_not_11_d0", 32'(r_o[0] & s_o[0]), 32'd0);
        chk("rs_not_11_d1", 32'(r_o[1] & s_o[1]), 32'd0);
    end

    function automatic logic [1:0] exp_rs(input int idx);
        case (idx)
            0, 4, 6: exp_rs = 2'b10;
            2, 5:    exp_rs = 2'b01;
            default: exp_rs = 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_rs"},   32'({r_o[d], s_o[d]}), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o[d]), 32'd0);
        chk({tag, "_done"}, 32'(done_o[d]), 32'd0);
        chk({tag, "_pass"}, 32'(pass_o[d]), 32'd0);
        chk({tag, "_err"},  32'(err_o[d]),  32'd0);
        chk({tag, "_ff"},   32'(ff_o[d]),   32'd0);
        chk({tag, "_fs"},   32'(fs_o[d]),   32'd0);
        chk({tag, "_step"}, 32'(step_o[d]), 32'd0);
    endtask

    // Starts a full sequence on instance d and pushes the expected result to
    // the scoreboard. It checks r/s, busy and step on every cycle, then checks
    // that done rises exactly 8*hold edges after the start edge. It also checks
    // that the popped result stays stable afterwards.
    // hold_start keeps start high throughout RUN. repulse re-pulses it mid-run.
    task automatic run_seq(input int d, input int hold, input int e_err, input int e_ff,
                           input int e_fs, input bit hold_start, input bit repulse);
        exp_t e;
        e.err  = e_err;
        e.ff   = e_ff;
        e.fs   = e_fs;
        e.pass = (e_err == 0) ? 1 : 0;
        sb.push_back(e);
        start_i[d] = 1'b1;
        tick();
        if (!hold_start) start_i[d] = 1'b0;
        for (int k = 0; k < 8 * hold; k++) begin
            chk("run_rs",   32'({r_o[d], s_o[d]}), 32'(exp_rs(k / hold)));
            chk("run_busy", 32'(busy_o[d]), 32'd1);
            chk("run_done", 32'(done_o[d]), 32'd0);
            chk("run_step", 32'(step_o[d]), 32'(k / hold));
            if (repulse && k == 5) start_i[d] = 1'b1;
            if (repulse && k == 6) start_i[d] = 1'b0;
            tick();
        end
        start_i[d] = 1'b0;
        e = sb.pop_front();
        for (int j = 0; j < 3; j++) begin
            chk("done_flag", 32'(done_o[d]), 32'd1);
            chk("done_busy", 32'(busy_o[d]), 32'd0);
            chk("done_rs",   32'({r_o[d], s_o[d]}), 32'd0);
            chk("done_pass", 32'(pass_o[d]), 32'(e.pass));
            chk("done_err",  32'(err_o[d]),  32'(e.err));
            chk("done_ff",   32'(ff_o[d]),   32'(e.ff));
            chk("done_fs",   32'(fs_o[d]),   32'(e.fs));
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        mode[0]    = 0;
        mode[1]    = 0;
        tick();
        tick();
        chk_idle(0, "reset_d0");
        chk_idle(1, "reset_d1");
        rst = 1'b0;
        tick();

        // Correct flip-flop: pass.
        run_seq(0, 4, 0, 0, 0, 1'b0, 1'b0);
        // q stuck at 0: steps 2, 3 and 5 fail.
        mode[0] = 1;
        run_seq(0, 4, 3, 2, 1, 1'b0, 1'b0);
        // qb equal to q: every step fails.
        mode[0] = 2;
        run_seq(0, 4, 8, 0, 1, 1'b0, 1'b0);
        // Start held high through RUN, from DONE with stale errors.
        mode[0] = 0;
        run_seq(0, 4, 0, 0, 0, 1'b1, 1'b0);
        // Start re-pulsed in the middle of RUN.
        run_seq(0, 4, 0, 0, 0, 1'b0, 1'b1);

        // Reset during step 3, with a fault present so errors have accumulated.
        mode[0] = 1;
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        chk("pre_rst_step", 32'(step_o[0]), 32'd3);
        chk("pre_rst_err",  32'(err_o[0]),  32'd1);
        rst = 1'b1;
        tick();
        chk_idle(0, "midrst");
        rst = 1'b0;
        mode[0] = 0;
        tick();
        run_seq(0, 4, 0, 0, 0, 1'b0, 1'b0);

        // HOLD_CYCLES=2 with a correct flip-flop.
        run_seq(1, 2, 0, 0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
